// File: rtl/ram_sp_be_clr.sv
// ram_sp_be_clr -- parametrised single-port synchronous RAM with byte-lane
// write enables, registered read with a valid strobe, req/ready handshake,
// a hardware clear engine and an address range check.
//
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous active-low reset
//   req       in   1       access request, taken when ready=1 at a clk edge
//   write_en  in   1       1=write, 0=read (qualified by req)
//   addr      in   ADDR_W  word address
//   byte_en   in   BE_W    per-byte write enable (bit i -> data_in[8i+7:8i])
//   data_in   in   DATA_W  write data
//   clear     in   1       single-cycle pulse that restarts the clear engine
//   ready     out  1       idle and no clear request this cycle
//   busy      out  1       registered; high while the clear engine sweeps
//   data_out  out  DATA_W  registered read data; holds between reads
//   rd_valid  out  1       one-cycle pulse per accepted read
//   addr_err  out  1       one-cycle pulse per accepted access with addr>=DEPTH
module ram_sp_be_clr #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          DEPTH    = 8,
  parameter int unsigned          ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  clear,
  output logic                  ready,
  output logic                  busy,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  addr_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_clr_ptr, w_clr_ptr_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [DATA_W-1:0]    r_data_out;
  logic                 r_rd_valid;
  logic                 r_addr_err;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic w_ready;
  logic w_acc;
  logic w_in_range;
  logic w_wr_ok;
  logic w_rd_acc;
  logic w_clr_we;

  assign w_ready    = (r_state == S_IDLE) & ~clear;
  assign w_acc      = req & w_ready;
  // Zero-extend so the compare also works when DEPTH == 2**ADDR_W.
  assign w_in_range = ({1'b0, addr} < DEPTH_L);
  assign w_wr_ok    = w_acc & write_en & w_in_range;
  assign w_rd_acc   = w_acc & ~write_en;
  assign w_clr_we   = (r_state == S_CLEAR);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_busy_nxt    = r_busy;
    unique case (r_state)
      S_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST) begin
          w_state_nxt   = S_IDLE;
          w_busy_nxt    = 1'b0;
          w_clr_ptr_nxt = '0;
        end
      end
      S_IDLE: begin
        if (clear) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
          w_busy_nxt    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_CLEAR;
      r_clr_ptr  <= '0;
      r_busy     <= 1'b1;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_ptr  <= w_clr_ptr_nxt;
      r_busy     <= w_busy_nxt;
      r_rd_valid <= w_rd_acc;
      r_addr_err <= w_acc & ~w_in_range;
      if (w_rd_acc && w_in_range) begin
        r_data_out <= r_mem[addr];
      end
    end
  end

  // Storage has no reset; the clear sweep initialises it. Accesses are only
  // accepted in IDLE, so sweep and access writes never coincide.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= INIT_VAL;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (byte_en[i]) begin
          r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  assign ready    = w_ready;
  assign busy     = r_busy;
  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// tb_ram_sp_be_clr -- directed and randomised checks of ram_sp_be_clr
// (DATA_W=16, DEPTH=12, INIT_VAL=16'h5A5A) against a word-array reference.
module tb_ram_sp_be_clr;

  localparam int DW    = 16;
  localparam int DEP   = 12;
  localparam int AW    = 4;
  localparam logic [DW-1:0] INITV = 16'h5A5A;

  logic          clk;
  logic          reset;
  logic          req;
  logic          write_en;
  logic [AW-1:0] addr;
  logic [1:0]    byte_en;
  logic [DW-1:0] data_in;
  logic          clear;
  logic          ready;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          addr_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEP];
  logic [DW-1:0] exp_dout;

  ram_sp_be_clr #(
    .DATA_W  (DW),
    .DEPTH   (DEP),
    .ADDR_W  (AW),
    .INIT_VAL(INITV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .write_en(write_en),
    .addr    (addr),
    .byte_en (byte_en),
    .data_in (data_in),
    .clear   (clear),
    .ready   (ready),
    .busy    (busy),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < DEP; i++) model_mem[i] = INITV;
  endtask

  // One accepted access; response checked right after its accepting edge.
  // req is left high so consecutive calls form back-to-back accesses.
  task automatic access(input logic we, input int a, input logic [1:0] be,
                        input logic [DW-1:0] d, input string tag);
    logic oob;
    req = 1'b1; write_en = we; addr = AW'(a); byte_en = be; data_in = d;
    #1;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    oob = (a >= DEP);
    if (!oob) begin
      if (we) begin
        if (be[0]) model_mem[a][7:0]  = d[7:0];
        if (be[1]) model_mem[a][15:8] = d[15:8];
      end else begin
        exp_dout = model_mem[a];
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_rdv"},  32'(rd_valid), 32'(!we));
    check({tag, "_aerr"}, 32'(addr_err), 32'(oob));
    check({tag, "_dout"}, 32'(data_out), 32'(exp_dout));
  endtask

  task automatic idle(input string tag);
    req = 1'b0; write_en = 1'b0;
    tick();
    check({tag, "_idle_rdv"},  32'(rd_valid), 32'd0);
    check({tag, "_idle_aerr"}, 32'(addr_err), 32'd0);
    check({tag, "_idle_dout"}, 32'(data_out), 32'(exp_dout));
  endtask

  // Counts edges until busy drops, keeping a read request pending the whole
  // time; optionally pulses clear mid-sweep, which must be ignored.
  task automatic wait_clear(input int pulse_at, input string tag);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 40) begin
      req = 1'b1; write_en = 1'b0; addr = AW'($urandom_range(0, 15));
      clear = (n + 1 == pulse_at);
      #1;
      check({tag, "_busy_ready"}, 32'(ready), 32'd0);
      tick();
      n++;
      check({tag, "_busy_rdv"},  32'(rd_valid), 32'd0);
      check({tag, "_busy_aerr"}, 32'(addr_err), 32'd0);
      if (!busy) done = 1;
    end
    req = 1'b0; clear = 1'b0;
    check({tag, "_sweep_len"}, 32'(n), 32'd12);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    model_fill();
  endtask

  task automatic random_phase(input int count, input string tag);
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle(tag);
      end else begin
        access(1'($urandom), $urandom_range(0, 15), 2'($urandom),
               16'($urandom), tag);
      end
    end
    idle(tag);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; write_en = 1'b0; addr = '0;
    byte_en = '0; data_in = '0; clear = 1'b0;
    exp_dout = '0;
    for (int i = 0; i < DEP; i++) model_mem[i] = 'x;

    // Reset state
    tick(); tick();
    check("rst_busy",  32'(busy),     32'd1);
    check("rst_ready", 32'(ready),    32'd0);
    check("rst_dout",  32'(data_out), 32'd0);
    check("rst_rdv",   32'(rd_valid), 32'd0);
    check("rst_aerr",  32'(addr_err), 32'd0);

    // 1: sweep length after release, then every word holds INIT_VAL
    reset = 1'b1;
    wait_clear(0, "t1");
    for (int i = 0; i < DEP; i++) access(1'b0, i, 2'b00, '0, "t1_rd");
    idle("t1");

    // 2: byte-lane merge
    access(1'b1, 3, 2'b11, 16'hBEEF, "t2_w0");
    access(1'b1, 3, 2'b01, 16'h1234, "t2_w1");
    access(1'b0, 3, 2'b00, '0, "t2_rd");
    check("t2_merge", 32'(data_out), 32'h0000BE34);
    access(1'b1, 4, 2'b00, 16'hFFFF, "t2_be0");
    access(1'b0, 4, 2'b00, '0, "t2_be0_rd");
    idle("t2");

    // 3: read-after-write, back-to-back reads
    access(1'b1, 11, 2'b11, 16'hA5A5, "t3_w");
    access(1'b0, 11, 2'b00, '0, "t3_raw");
    check("t3_raw_val", 32'(data_out), 32'h0000A5A5);
    access(1'b0, 0,  2'b00, '0, "t3_b2b0");
    access(1'b0, 11, 2'b00, '0, "t3_b2b1");
    idle("t3");

    // 4: out-of-range accesses
    access(1'b1, 12, 2'b11, 16'hFFFF, "t4_w");
    access(1'b0, 12, 2'b00, '0, "t4_r");
    access(1'b0, 15, 2'b00, '0, "t4_r15");
    access(1'b0, 0,  2'b00, '0, "t4_r0");
    check("t4_r0_val", 32'(data_out), 32'h00005A5A);
    idle("t4");

    random_phase(60, "rnd1");

    // 5: clear coincident with a read request drops the read
    access(1'b1, 5, 2'b11, 16'h0F0F, "t5_w");
    req = 1'b1; write_en = 1'b0; addr = 4'd5; clear = 1'b1;
    #1;
    check("t5_ready_clr", 32'(ready), 32'd0);
    tick();
    clear = 1'b0;
    check("t5_rdv_drop", 32'(rd_valid), 32'd0);
    check("t5_busy",     32'(busy),     32'd1);
    check("t5_dout",     32'(data_out), 32'(exp_dout));
    wait_clear(4, "t5");
    access(1'b0, 5, 2'b00, '0, "t5_rd");
    check("t5_rd_val", 32'(data_out), 32'h00005A5A);
    idle("t5");

    random_phase(60, "rnd2");

    // 6: reset in the middle of a sweep
    clear = 1'b1; req = 1'b0;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b0;
    exp_dout = '0;
    #1;
    check("t6_busy", 32'(busy),     32'd1);
    check("t6_dout", 32'(data_out), 32'd0);
    check("t6_rdv",  32'(rd_valid), 32'd0);
    tick(); tick();
    check("t6_busy_hold", 32'(busy), 32'd1);
    reset = 1'b1;
    wait_clear(0, "t6");
    for (int i = 0; i < DEP; i++) access(1'b0, i, 2'b00, '0, "t6_rd");
    idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
